bit_serial_alu: RTL and testbench
=================================

Name: bit_serial_alu

Overview:
- Parametrised, operation-complete successor to the CPU's fixed 8-bit serial datapath.
- Latches two WIDTH-bit operands and an opcode, then computes one result bit per clock, LSB first, through a single 1-bit slice.
- Reports the result and Z/C/N/V flags with a start/busy/done handshake.
- Supports multi-word chaining through an external carry-in, and a compare op that updates flags only.

Parameters:
- WIDTH, 8: operand/result width in bits; must be >= 2.
- CNTW, $clog2(WIDTH): bit-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  3  opcode; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin_en  in  1  1 = use cin as initial carry/shift-in; sampled with start.
- cin  in  1  external carry/shift-in; sampled with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  WIDTH  last committed result.
- flag_z  out  1  result bits all zero.
- flag_c  out  1  carry out (SUB/CMP: 1 = no borrow); SHL: bit shifted out.
- flag_n  out  1  MSB of the computed value.
- flag_v  out  1  signed overflow: carry into MSB XOR carry out; ADD/SUB/CMP only.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, all flags=0, counter=0, carry=0. Reset has priority over every other input. Reset during SHIFT aborts the operation; no done pulse follows.
- Opcodes:
  - 000 ADD: a+b+c0.
  - 001 SUB: a+~b+c0.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 PASSB.
  - 110 SHL: result bit i = a[i-1], bit 0 = c0, C = a[WIDTH-1].
  - 111 CMP: computed like SUB; result register is not written; flags are written.
- Initial carry c0:
  - cin_en=1: c0 = cin.
  - cin_en=0: c0 = 1 for SUB/CMP, 0 for all other ops.
- Logic ops and PASSB: C=0, V=0.
- State machine IDLE -> SHIFT -> DONE:
  - IDLE, start=1 at edge E0: latch a, b, op, c0 into shift registers and the carry flop; counter=0; go to SHIFT. busy=1 from E0.
  - SHIFT: each edge processes the bit at the LSB of the shift registers, shifts the result bit in at the MSB, updates carry and the sticky nonzero flag, and increments the counter. The edge with counter=WIDTH-1 (E_WIDTH) commits result and flags and moves to DONE with busy=0.
  - DONE: done=1 for exactly one cycle. At the next edge, start=1 launches a new operation (back-to-back; throughput WIDTH+1 cycles); start=0 returns to IDLE.
- Latency: done is high in the cycle following E_WIDTH, i.e. WIDTH edges after the start-sampling edge.
- start while busy: ignored. No queueing, and in-flight operands are unaffected.
- Input stability: a, b, op, cin, cin_en are don't-care except on the start-sampling edge.
- Holding outputs: result and flags hold their values between operations.
- Z on CMP: evaluated on the difference, not on the held result.
- Arithmetic: modulo 2^WIDTH; no saturation.

Decomposition:
- Package bit_serial_pkg:
  - op encodings: OP_ADD..OP_CMP, 3 bits.
  - state enum: ST_IDLE, ST_SHIFT, ST_DONE.
  - function c0_default(op).
- Sub-module serial_bit_slice (combinational 1-bit slice). Inputs: a_bit, b_bit, carry_in, prev_a, op. Outputs: r_bit, carry_out.
- Top level owns the FSM, counter, shift registers, carry flop, MSB carry-in capture for V, and the sticky Z.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 cin_en=0 -> done exactly 8 edges after the start edge; result=0x80; N=1, V=1, C=0, Z=0. busy is high for 8 cycles.
- SUB a=0x05 b=0x05 -> result=0x00; Z=1, C=1, V=0. Then CMP a=0x03 b=0x09 -> result stays 0x00; flags C=0, N=1, Z=0.
- Two-word chain: ADD 0xFF+0x01 -> result 0x00, C=1. Then ADD 0x00+0x00 with cin_en=1, cin=1 -> result 0x01, C=0.
- SHL a=0x81 cin_en=1 cin=1 -> result=0x03, C=1. Start pulsed mid-operation -> ignored. Back-to-back start in DONE -> second done exactly 9 cycles after the first.
- rst=1 on the 4th SHIFT cycle of an ADD -> next cycle: IDLE, busy=0, result=0, flags=0, and no done pulse ever follows.
- WIDTH=16, ADD 0xFFFF+0x0001 -> result=0x0000; Z=1, C=1; latency 16 edges.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// Shared encodings and helpers for the bit-serial ALU.
package bit_serial_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_CMP   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Subtraction-like ops start with carry 1 so that a + ~b + 1 = a - b.
  function automatic logic c0_default(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

  // Ops whose carry chain is meaningful for signed overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/serial_bit_slice.sv
// Combinational 1-bit ALU slice; the top level feeds it one bit per clock.
module serial_bit_slice
  import bit_serial_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       carry_in,
  input  logic       prev_a,
  input  logic [2:0] op,
  output logic       r_bit,
  output logic       carry_out
);

  logic b_eff;

  assign b_eff = ((op == OP_SUB) || (op == OP_CMP)) ? ~b_bit : b_bit;

  // Per-opcode bit result and carry; logic ops never produce a carry.
  always_comb begin
    r_bit     = 1'b0;
    carry_out = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_CMP: begin
        r_bit     = a_bit ^ b_eff ^ carry_in;
        carry_out = (a_bit & b_eff) | (a_bit & carry_in) | (b_eff & carry_in);
      end
      OP_AND:   r_bit = a_bit & b_bit;
      OP_OR:    r_bit = a_bit | b_bit;
      OP_XOR:   r_bit = a_bit ^ b_bit;
      OP_PASSB: r_bit = b_bit;
      OP_SHL: begin
        // Carry chain doubles as the shift chain: the bit leaving is a_bit.
        r_bit     = prev_a;
        carry_out = a_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: latches operands, then produces one result bit per clock
// LSB first through serial_bit_slice, committing result and Z/C/N/V flags.
module bit_serial_alu
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_en,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CNTW = $clog2(WIDTH);

  state_e           state;
  logic [CNTW-1:0]  cnt;
  logic             carry_q;
  logic             nz_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic             r_bit;
  logic             carry_out;
  logic             launch;
  logic             last;

  assign launch = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (cnt == CNTW'(WIDTH - 1));
  assign r_next = {r_bit, r_sr[WIDTH-1:1]};

  // For SHL the carry flop already holds the previously consumed a bit
  // (or the initial shift-in), so it serves as prev_a.
  serial_bit_slice u_slice (
    .a_bit     (a_sr[0]),
    .b_bit     (b_sr[0]),
    .carry_in  (carry_q),
    .prev_a    (carry_q),
    .op        (op_q),
    .r_bit     (r_bit),
    .carry_out (carry_out)
  );

  // Operand/result shift registers: load on launch, shift right while active.
  always_ff @(posedge clk) begin
    if (launch) begin
      a_sr <= a;
      b_sr <= b;
      op_q <= op;
    end else if (state == ST_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_next;
    end
  end

  // Sequencer, carry/sticky-zero tracking and result/flag commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      carry_q <= 1'b0;
      nz_q    <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= ST_SHIFT;
            busy    <= 1'b1;
            cnt     <= '0;
            carry_q <= cin_en ? cin : c0_default(op);
            nz_q    <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          carry_q <= carry_out;
          nz_q    <= nz_q | r_bit;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            cnt    <= '0;
            if (op_q != OP_CMP) result <= r_next;
            flag_z <= ~(nz_q | r_bit);
            flag_c <= carry_out;
            flag_n <= r_bit;
            // carry_q is the carry into the MSB at this point.
            flag_v <= is_arith(op_q) ? (carry_q ^ carry_out) : 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed table-driven bench for bit_serial_alu (WIDTH=8 and WIDTH=16).
module tb_bit_serial_alu;
  import bit_serial_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic        cin_en, cin;
  logic        busy, done;
  logic [7:0]  result;
  logic        flag_z, flag_c, flag_n, flag_v;

  logic        start16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] result16;
  logic        z16, c16, n16, v16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cin_en(cin_en), .cin(cin), .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );

  bit_serial_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op), .a(a16), .b(b16),
    .cin_en(cin_en), .cin(cin), .busy(busy16), .done(done16), .result(result16),
    .flag_z(z16), .flag_c(c16), .flag_n(n16), .flag_v(v16)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ce;
    logic       ci;
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       n;
    logic       v;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one 8-bit op from just after an edge; returns edges until done,
  // busy-high cycles seen, and the cycle stamp of the done sample.
  task automatic run8(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ce, input logic ci, input int glitch,
                      output int lat, output int busyc, output int done_cyc);
    op = o; a = ia; b = ib; cin_en = ce; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; cin = ~ci; cin_en = ~ce;
    lat = 0; busyc = 0;
    while (!done && lat < 40) begin
      if (busy) busyc++;
      if (glitch != 0 && lat == glitch) begin
        start = 1'b1; op = OP_XOR; a = 8'hFF; b = 8'h0F; cin_en = 1'b1; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    done_cyc = cyc;
  endtask

  task automatic chk_all(input string tag, input vec_t v, input int lat, input int busyc);
    chk({tag, " latency"}, lat, 8);
    chk({tag, " busy_cycles"}, busyc, 8);
    chk({tag, " result"}, result, v.r);
    chk({tag, " Z"}, flag_z, v.z);
    chk({tag, " C"}, flag_c, v.c);
    chk({tag, " N"}, flag_n, v.n);
    chk({tag, " V"}, flag_v, v.v);
  endtask

  initial begin
    int lat, bc, dc, dc2, seen;
    vec_t v;

    vt[0]  = '{OP_ADD,   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[1]  = '{OP_SUB,   8'h05, 8'h05, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{OP_CMP,   8'h03, 8'h09, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{OP_ADD,   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{OP_ADD,   8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{OP_SHL,   8'h81, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{OP_SHL,   8'h40, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{OP_SUB,   8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{OP_SUB,   8'h05, 8'h05, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{OP_AND,   8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{OP_OR,    8'h80, 8'h01, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{OP_XOR,   8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{OP_PASSB, 8'h12, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[13] = '{OP_CMP,   8'h7F, 8'hFF, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[14] = '{OP_AND,   8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; start16 = 1'b0; op = OP_ADD;
    a = '0; b = '0; a16 = '0; b16 = '0; cin_en = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset flags", {flag_z, flag_c, flag_n, flag_v}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of single operations, each followed by one idle cycle.
    for (int i = 0; i < 15; i++) begin
      v = vt[i];
      run8(v.op, v.a, v.b, v.ce, v.ci, 0, lat, bc, dc);
      chk_all($sformatf("v%0d", i), v, lat, bc);
      @(posedge clk); #1;
      chk($sformatf("v%0d done_pulse_width", i), done, 0);
    end

    // start pulsed mid-operation must not disturb the running ADD.
    run8(OP_ADD, 8'h10, 8'h20, 1'b0, 1'b0, 3, lat, bc, dc);
    chk("glitch latency", lat, 8);
    chk("glitch result", result, 8'h30);
    chk("glitch C", flag_c, 0);
    @(posedge clk); #1;

    // Back-to-back launch from DONE.
    run8(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0, 0, lat, bc, dc);
    chk("b2b first result", result, 8'h03);
    run8(OP_XOR, 8'hF0, 8'hFF, 1'b0, 1'b0, 0, lat, bc, dc2);
    chk("b2b second result", result, 8'h0F);
    chk("b2b done spacing", dc2 - dc, 9);
    @(posedge clk); #1;

    // Leave non-zero result/flags, then reset in the 4th SHIFT cycle.
    run8(OP_SUB, 8'h80, 8'h01, 1'b0, 1'b0, 0, lat, bc, dc);
    chk("pre-reset result", result, 8'h7F);
    @(posedge clk); #1;
    op = OP_ADD; a = 8'h11; b = 8'h22; cin_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-op busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort flags", {flag_z, flag_c, flag_n, flag_v}, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("abort no done", seen, 0);

    run8(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, 0, lat, bc, dc);
    chk("recover latency", lat, 8);
    chk("recover result", result, 8'h80);

    // WIDTH=16 instance.
    op = OP_ADD; a16 = 16'hFFFF; b16 = 16'h0001; cin_en = 1'b0; cin = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16 latency", lat, 16);
    chk("w16 result", result16, 16'h0000);
    chk("w16 Z", z16, 1);
    chk("w16 C", c16, 1);
    chk("w16 N", n16, 0);
    chk("w16 V", v16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
